// File: rtl/mips_mem_arbiter_pkg.sv
// Shared definitions for the pipe_MIPS32 unified-memory arbiter.
package mips_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned MEM_DATA_W = 32;

    localparam int unsigned REQ_LD = 0;
    localparam int unsigned REQ_DM = 1;
    localparam int unsigned REQ_IF = 2;

    typedef logic [2:0] req_vec_t;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Requester and memory-side signals of the unified-memory arbiter.
interface mips_mem_arbiter_if #(
    parameter int unsigned ADDR_W = mips_mem_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W = mips_mem_pkg::MEM_DATA_W
);
    logic              halt;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [2:0]        gnt;
    logic [2:0]        done;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [2:0]        streak;

    modport slave (
        input  halt, ld_req, ld_we, ld_addr, ld_wdata,
               dm_req, dm_we, dm_addr, dm_wdata, if_req, if_addr, mem_rdata,
        output gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata, streak
    );

    modport master (
        output halt, ld_req, ld_we, ld_addr, ld_wdata,
               dm_req, dm_we, dm_addr, dm_wdata, if_req, if_addr, mem_rdata,
        input  gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata, streak
    );

endinterface

// File: rtl/mips_mem_arbiter_pick.sv
// Fixed-priority winner select: LD > DM > IF, with IF promoted over DM once the streak is full.
module mips_mem_arb_pick
    import mips_mem_pkg::*;
(
    input  req_vec_t req,
    input  logic     streak_full,
    output req_vec_t winner
);

    always_comb begin
        winner = '0;
        if (req[REQ_LD]) begin
            winner[REQ_LD] = 1'b1;
        end else if (req[REQ_IF] && streak_full) begin
            winner[REQ_IF] = 1'b1;
        end else if (req[REQ_DM]) begin
            winner[REQ_DM] = 1'b1;
        end else if (req[REQ_IF]) begin
            winner[REQ_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter for loader, data and fetch requesters with wait-state sequencing.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W          = MEM_ADDR_W,
    parameter int unsigned DATA_W          = MEM_DATA_W,
    parameter int unsigned WAIT_STATES     = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic            clk1,
    input  logic            rst,
    mips_mem_arbiter_if.slave bus
);

    state_e            state, state_next;
    req_vec_t          req_eff, winner, owner, gnt_q, done_q;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              we_q;
    logic [2:0]        streak_q;
    logic              if_eff, streak_full, last_cycle, accept;

    assign if_eff      = bus.if_req & ~bus.halt;
    assign req_eff     = {if_eff, bus.dm_req, bus.ld_req};
    assign streak_full = (streak_q == 3'(MAX_DATA_STREAK));
    assign last_cycle  = (state == S_BUSY) && (cnt == '0);

    mips_mem_arb_pick u_pick (
        .req         (req_eff),
        .streak_full (streak_full),
        .winner      (winner)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req_eff) begin
                    state_next = S_BUSY;
                    accept     = 1'b1;
                end
            end
            S_BUSY: begin
                if (last_cycle) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            owner    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            streak_q <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            if (accept) begin
                owner <= winner;
                gnt_q <= winner;
                cnt   <= 4'(WAIT_STATES);
                if (winner[REQ_LD]) begin
                    addr_q  <= bus.ld_addr;
                    we_q    <= bus.ld_we;
                    wdata_q <= bus.ld_wdata;
                end else if (winner[REQ_DM]) begin
                    addr_q  <= bus.dm_addr;
                    we_q    <= bus.dm_we;
                    wdata_q <= bus.dm_wdata;
                end else begin
                    addr_q  <= bus.if_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end
            end else if (state == S_BUSY) begin
                if (cnt != '0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    done_q <= owner;
                    if (!we_q) rdata_q <= bus.mem_rdata;
                end
            end
            // Streak only moves on arbitration cycles; BUSY leaves it untouched.
            if (state == S_IDLE) begin
                if (winner[REQ_IF] || !if_eff) begin
                    streak_q <= '0;
                end else if (winner[REQ_DM] && !streak_full) begin
                    streak_q <= streak_q + 3'd1;
                end
            end
        end
    end

    // Gating with rst keeps a reset landing on a final write cycle from committing it.
    assign bus.mem_we    = last_cycle & we_q & ~rst;
    assign bus.mem_en    = (state == S_BUSY);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.streak    = streak_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter (WAIT_STATES=1 main instance, WAIT_STATES=0 side instance).
module tb_mips_mem_arbiter;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    mips_mem_arbiter_if bus ();
    mips_mem_arbiter_if bus0 ();

    mips_mem_arbiter #(.WAIT_STATES(1), .MAX_DATA_STREAK(4)) u_dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    mips_mem_arbiter #(.WAIT_STATES(0), .MAX_DATA_STREAK(4)) u_dut0 (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus0)
    );

    logic [31:0] mem  [0:1023];
    logic [31:0] mem0 [0:1023];

    always @(posedge clk1) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus0.mem_en && bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
    end
    assign bus.mem_rdata  = mem[bus.mem_addr];
    assign bus0.mem_rdata = mem0[bus0.mem_addr];

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 32'hA000_0000 | 32'(i);
            mem0[i] = 32'h0;
        end
        mem[120]  = 32'd123;
        mem0[120] = 32'd123;

        bus.halt = 0; bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.if_req = 0; bus.if_addr = '0;
        bus0.halt = 0; bus0.ld_req = 0; bus0.ld_we = 0; bus0.ld_addr = '0; bus0.ld_wdata = '0;
        bus0.dm_req = 0; bus0.dm_we = 0; bus0.dm_addr = '0; bus0.dm_wdata = '0;
        bus0.if_req = 0; bus0.if_addr = '0;

        // Reset state
        tick(); tick();
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_streak", 32'(bus.streak), 0);
        rst = 0;

        // 1. Loader write to addr 0
        bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 10'd0; bus.ld_wdata = 32'h2801000a;
        tick();
        chk("ldw_gnt", 32'(bus.gnt), 32'b001);
        chk("ldw_en_t1", 32'(bus.mem_en), 1);
        chk("ldw_we_t1", 32'(bus.mem_we), 0);
        bus.ld_req = 0; bus.ld_we = 0;
        tick();
        chk("ldw_gnt_t2", 32'(bus.gnt), 0);
        chk("ldw_we_t2", 32'(bus.mem_we), 1);
        chk("ldw_wdata", bus.mem_wdata, 32'h2801000a);
        tick();
        chk("ldw_done", 32'(bus.done), 32'b001);
        chk("ldw_we_t3", 32'(bus.mem_we), 0);
        chk("ldw_en_t3", 32'(bus.mem_en), 0);
        chk("ldw_mem0", mem[0], 32'h2801000a);
        chk("ldw_rdata_kept", bus.rdata, 0);

        // 2. Data read of addr 120
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'd120;
        tick();
        chk("dmr_gnt", 32'(bus.gnt), 32'b010);
        bus.dm_req = 0;
        tick();
        chk("dmr_done_early", 32'(bus.done), 0);
        tick();
        chk("dmr_done", 32'(bus.done), 32'b010);
        chk("dmr_rdata", bus.rdata, 32'd123);

        // 2b. Same read with zero wait states
        bus0.dm_req = 1; bus0.dm_we = 0; bus0.dm_addr = 10'd120;
        tick();
        chk("ws0_gnt", 32'(bus0.gnt), 32'b010);
        chk("ws0_en", 32'(bus0.mem_en), 1);
        bus0.dm_req = 0;
        tick();
        chk("ws0_done", 32'(bus0.done), 32'b010);
        chk("ws0_rdata", bus0.rdata, 32'd123);

        // 3. Priority LD > DM > IF
        bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 10'd5;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'd6;
        bus.if_req = 1; bus.if_addr = 10'd7;
        tick();
        chk("pri_gnt_ld", 32'(bus.gnt), 32'b001);
        chk("pri_addr_ld", 32'(bus.mem_addr), 5);
        bus.ld_req = 0;
        tick();
        chk("pri_gap1", 32'(bus.gnt), 0);
        tick();
        chk("pri_done_ld", 32'(bus.done), 32'b001);
        chk("pri_rdata_ld", bus.rdata, 32'hA000_0005);
        tick();
        chk("pri_gnt_dm", 32'(bus.gnt), 32'b010);
        chk("pri_addr_dm", 32'(bus.mem_addr), 6);
        chk("pri_streak_dm", 32'(bus.streak), 1);
        bus.dm_req = 0;
        tick(); tick();
        chk("pri_done_dm", 32'(bus.done), 32'b010);
        chk("pri_rdata_dm", bus.rdata, 32'hA000_0006);
        tick();
        chk("pri_gnt_if", 32'(bus.gnt), 32'b100);
        chk("pri_streak_if", 32'(bus.streak), 0);
        bus.if_req = 0;
        tick(); tick();
        chk("pri_done_if", 32'(bus.done), 32'b100);
        chk("pri_rdata_if", bus.rdata, 32'hA000_0007);

        // 4. Starvation override after 4 DM grants
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'd8;
        bus.if_req = 1; bus.if_addr = 10'd9;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("stv_gnt_dm%0d", k), 32'(bus.gnt), 32'b010);
            chk($sformatf("stv_streak%0d", k), 32'(bus.streak), 32'(k + 1));
            tick(); tick();
        end
        tick();
        chk("stv_gnt_if", 32'(bus.gnt), 32'b100);
        chk("stv_streak_clr", 32'(bus.streak), 0);
        chk("stv_addr_if", 32'(bus.mem_addr), 9);
        bus.dm_req = 0; bus.if_req = 0;
        tick(); tick();
        chk("stv_done_if", 32'(bus.done), 32'b100);

        // 5. Halt masks fetch; halt during an access does not abort it
        bus.halt = 1; bus.if_req = 1; bus.if_addr = 10'd10;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("hlt_gnt%0d", k), 32'(bus.gnt), 0);
            chk($sformatf("hlt_en%0d", k), 32'(bus.mem_en), 0);
        end
        bus.halt = 0;
        tick();
        chk("hlt_gnt_if", 32'(bus.gnt), 32'b100);
        bus.if_req = 0; bus.halt = 1;
        tick();
        chk("hlt_en_busy", 32'(bus.mem_en), 1);
        tick();
        chk("hlt_done_if", 32'(bus.done), 32'b100);
        chk("hlt_rdata", bus.rdata, 32'hA000_000A);
        bus.halt = 0;

        // 6. Reset in the first BUSY cycle of a write to addr 121
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 10'd121; bus.dm_wdata = 32'hDEADBEEF;
        tick();
        chk("rsw_gnt", 32'(bus.gnt), 32'b010);
        chk("rsw_we_t1", 32'(bus.mem_we), 0);
        bus.dm_req = 0; bus.dm_we = 0;
        rst = 1;
        tick();
        chk("rsw_gnt0", 32'(bus.gnt), 0);
        chk("rsw_done0", 32'(bus.done), 0);
        chk("rsw_rdata0", bus.rdata, 0);
        chk("rsw_en0", 32'(bus.mem_en), 0);
        chk("rsw_we0", 32'(bus.mem_we), 0);
        chk("rsw_addr0", 32'(bus.mem_addr), 0);
        chk("rsw_wdata0", bus.mem_wdata, 0);
        chk("rsw_streak0", 32'(bus.streak), 0);
        rst = 0;
        tick();
        chk("rsw_done_t3", 32'(bus.done), 0);
        tick();
        chk("rsw_done_t4", 32'(bus.done), 0);
        chk("rsw_mem121", mem[121], 32'hA000_0079);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
